// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program loader and the
// instruction memory it feeds.
package prog_loader_pkg;

  localparam int unsigned IMEM_DEPTH_DEF = 256;
  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned RUN_W_DEF      = 16;
  localparam int unsigned WORD_W         = 32;

  // addi x0,x0,0
  localparam logic [WORD_W-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot/run sequencer: streams a program into instruction memory, pads the
// remainder with NOPs, then releases the core for a fixed cycle budget.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned RUN_W      = RUN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err_len
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(IMEM_DEPTH - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  addr, addr_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [RUN_W-1:0]  run_cnt, run_cnt_d;
  logic              run_inf, run_inf_d;
  logic              ready_d, we_d, core_rst_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [31:0]       wdata_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr       <= '0;
      len_q      <= '0;
      run_cnt    <= '0;
      run_inf    <= 1'b0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_d;
      addr       <= addr_d;
      len_q      <= len_d;
      run_cnt    <= run_cnt_d;
      run_inf    <= run_inf_d;
      s_ready    <= ready_d;
      imem_we    <= we_d;
      imem_addr  <= waddr_d;
      imem_wdata <= wdata_d;
      core_rst   <= core_rst_d;
      busy       <= busy_d;
      done       <= done_d;
      err_len    <= err_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d   = state;
    addr_d    = addr;
    len_d     = len_q;
    run_cnt_d = run_cnt;
    run_inf_d = run_inf;
    we_d      = 1'b0;
    waddr_d   = imem_addr;
    wdata_d   = imem_wdata;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          if (load_len > DEPTH_C) begin
            err_d = 1'b1;
          end else begin
            len_d     = load_len;
            run_cnt_d = run_cycles;
            run_inf_d = (run_cycles == '0);
            addr_d    = '0;
            state_d   = (load_len == '0) ? ST_PAD : ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (s_valid && s_ready) begin
          we_d    = 1'b1;
          waddr_d = addr[ADDR_W-1:0];
          wdata_d = s_data;
          addr_d  = addr + CNT_W'(1);
          if (addr_d == len_q) begin
            state_d = (len_q == DEPTH_C) ? ST_RUN : ST_PAD;
          end
        end
      end
      ST_PAD: begin
        we_d    = 1'b1;
        waddr_d = addr[ADDR_W-1:0];
        wdata_d = NOP_INSN;
        addr_d  = addr + CNT_W'(1);
        if (addr == LAST_C) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A zero budget means run until the host resets the loader.
        if (!run_inf) begin
          if (run_cnt == '0) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            run_cnt_d = run_cnt - RUN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_FILL);
    busy_d  = (state_d == ST_FILL) || (state_d == ST_PAD) || (state_d == ST_RUN);
    // Hold reset one extra cycle on entry to RUN so the last write lands
    // before the first fetch; reassert as soon as a reload is accepted.
    core_rst_d = !((state == ST_RUN) || (state == ST_DONE)) ||
                 !((state_d == ST_RUN) || (state_d == ST_DONE));
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against an expected
// memory image and cycle-level timing rules.
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned RW    = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic [RW-1:0] run_cycles = '0;
  logic          s_valid = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_ready, imem_we, core_rst, busy, done, err_len;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  int errors = 0;
  int checks = 0;

  prog_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .RUN_W(RW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
    .run_cycles (run_cycles),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  // Instruction memory model and event log, sampled on the falling edge.
  logic [31:0] mem [DEPTH];
  int cyc = 0, wr_cnt = 0, order_err = 0, done_cnt = 0, err_cnt = 0;
  int last_wr_cyc = 0, fall_cyc = 0, done_cyc = 0, last_addr = -1;
  logic prev_rst = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      if (imem_addr != 0 && int'(imem_addr) != last_addr + 1) order_err++;
      last_addr = int'(imem_addr);
      mem[imem_addr] = imem_wdata;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (prev_rst && !core_rst) fall_cyc = cyc;
    prev_rst = core_rst;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_len) err_cnt++;
  end

  task automatic do_load(input int len, input int run, input int mode, input bit poke);
    logic [31:0] prog [DEPTH];
    logic [31:0] exp_w;
    int idx, g, w0, d0, o0, bad, ps;
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    w0 = wr_cnt; d0 = done_cnt; o0 = order_err;
    @(negedge clk);
    load_start = 1'b1; load_len = 9'(len); run_cycles = 16'(run);
    @(negedge clk);
    load_start = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_state len=%0d: core_rst=%b busy=%b, required 1 1", len, core_rst, busy);
    end
    idx = 0; g = 0;
    while (idx < len && g < 5000) begin
      if (mode == 0)      s_valid = 1'b1;
      else if (mode == 1) s_valid = (g % 2 == 0);
      else                s_valid = 1'($urandom_range(0, 1));
      s_data = prog[idx];
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      g++;
    end
    checks++;
    if (idx != len) begin
      errors++;
      $display("FAIL stream_accept len=%0d: accepted %0d words, required %0d", len, idx, len);
    end
    if (len > 0) begin
      checks++;
      if (s_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_drop len=%0d: s_ready=%b after last word, required 0", len, s_ready);
      end
    end
    // Keep offering a junk word; it must never be accepted.
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    if (run > 0) begin
      g = 0; ps = 0;
      while (done_cnt == d0 && g < DEPTH + run + 100) begin
        @(negedge clk);
        g++;
        if (poke) begin
          if (ps == 0 && !core_rst) begin
            load_start = 1'b1; load_len = 9'd3; ps = 1;
          end else if (ps == 1) begin
            load_start = 1'b0; ps = 2;
          end
        end
      end
      load_start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (done_cnt - d0 != 1) begin
        errors++;
        $display("FAIL done_count len=%0d: done pulses=%0d, required 1", len, done_cnt - d0);
      end
      checks++;
      if (done_cyc - fall_cyc != run) begin
        errors++;
        $display("FAIL run_length len=%0d: done %0d cycles after core_rst fall, required %0d", len, done_cyc - fall_cyc, run);
      end
      checks++;
      if (busy !== 1'b0 || core_rst !== 1'b0) begin
        errors++;
        $display("FAIL done_state len=%0d: busy=%b core_rst=%b, required 0 0", len, busy, core_rst);
      end
    end else begin
      repeat (DEPTH + 300) @(negedge clk);
      checks++;
      if (done_cnt != d0 || core_rst !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL run_forever: done pulses=%0d core_rst=%b busy=%b, required 0 0 1", done_cnt - d0, core_rst, busy);
      end
    end
    checks++;
    if (wr_cnt - w0 != DEPTH) begin
      errors++;
      $display("FAIL write_count len=%0d: %0d writes, required %0d", len, wr_cnt - w0, DEPTH);
    end
    checks++;
    if (order_err != o0) begin
      errors++;
      $display("FAIL write_order len=%0d: %0d out-of-order writes, required 0", len, order_err - o0);
    end
    checks++;
    if (fall_cyc - last_wr_cyc != 1) begin
      errors++;
      $display("FAIL rst_release len=%0d: core_rst fell %0d cycles after last write, required 1", len, fall_cyc - last_wr_cyc);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_w = (i < len) ? prog[i] : NOP;
      if (mem[i] !== exp_w) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mem_image len=%0d: %0d words differ, required 0", len, bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: core_rst=%b s_ready=%b busy=%b done=%b err_len=%b, required 1 0 0 0 0",
               core_rst, s_ready, busy, done, err_len);
    end
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem: we=%b addr=%h wdata=%h, required 0 00 00000000", imem_we, imem_addr, imem_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();        do_load(8, 100, 0, 1'b0); endtask
  task automatic test_toggle_valid(); do_load(4, 20, 1, 1'b0);  endtask
  task automatic test_len_zero();     do_load(0, 10, 0, 1'b0);  endtask
  task automatic test_full_len();     do_load(256, 5, 2, 1'b0); endtask
  task automatic test_run_ignore();   do_load(5, 60, 0, 1'b1);  endtask
  task automatic test_back_to_back(); do_load(3, 15, 2, 1'b0);  endtask

  task automatic test_err_len();
    int w0, e0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = wr_cnt; e0 = err_cnt;
    load_start = 1'b1; load_len = 9'd257; run_cycles = 16'd10;
    @(negedge clk);
    load_start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL err_pulse: err_len high %0d cycles, required 1", err_cnt - e0);
    end
    checks++;
    if (wr_cnt != w0 || busy !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL err_idle: writes=%0d busy=%b core_rst=%b, required 0 0 1", wr_cnt - w0, busy, core_rst);
    end
  endtask

  task automatic test_reset_mid_fill();
    int idx, g, w0;
    @(negedge clk);
    load_start = 1'b1; load_len = 9'd10; run_cycles = 16'd20;
    @(negedge clk);
    load_start = 1'b0;
    w0 = wr_cnt; idx = 0; g = 0;
    while (idx < 3 && g < 100) begin
      s_valid = 1'b1; s_data = $urandom;
      if (s_ready) idx++;
      @(negedge clk);
      g++;
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (core_rst !== 1'b1 || s_ready !== 1'b0 || imem_we !== 1'b0 || busy !== 1'b0 || imem_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: core_rst=%b s_ready=%b we=%b busy=%b addr=%h, required 1 0 0 0 00",
               core_rst, s_ready, imem_we, busy, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt - w0 != 3) begin
      errors++;
      $display("FAIL mid_reset_writes: %0d writes, required 3", wr_cnt - w0);
    end
    do_load(6, 30, 2, 1'b0);
  endtask

  task automatic test_run_forever();
    do_load(2, 0, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_toggle_valid();
    test_len_zero();
    test_err_len();
    test_full_len();
    test_reset_mid_fill();
    test_run_ignore();
    test_back_to_back();
    test_run_forever();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
